// File: rtl/arc_meter_pkg.sv
// Shared definitions for the timing-arc delay meter.
//   - FSM state encodings (IDLE -> SETTLE -> MEASURE -> RESULT)
//   - result status codes
//   - synchronizer depth and the fixed loopback offset it introduces
package arc_meter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE    = 2'd0;
    localparam state_t S_SETTLE  = 2'd1;
    localparam state_t S_MEASURE = 2'd2;
    localparam state_t S_RESULT  = 2'd3;

    typedef logic [1:0] status_t;

    localparam status_t ST_OK          = 2'b00;
    localparam status_t ST_TIMEOUT     = 2'b01;
    localparam status_t ST_SETTLE_FAIL = 2'b10;

    localparam int unsigned SYNC_STAGES = 2;

    // A zero-delay loopback reads this many edges: two synchronizer stages plus
    // the edge that registers the detection.
    localparam int unsigned LOOPBACK_OFFSET = 3;

endpackage

// File: rtl/arc_delay_meter_sense_sync.sv
// Multi-flop synchronizer for the asynchronous cell-under-test output pin.
// Ports:
//   CP  - clock, rising edge
//   CDN - asynchronous active-low clear (all stages to 0)
//   d   - asynchronous input
//   q   - synchronized output, SYNC_STAGES edges of latency
module sense_sync
    import arc_meter_pkg::*;
(
    input  logic CP,
    input  logic CDN,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/arc_delay_meter.sv
// Timing-arc characterization engine. For each request it drives an initial
// level into the cell-under-test, checks the output settled to the matching
// level, launches the transition and counts CP edges until the expected output
// edge is seen through the synchronizer. One result record per request.
// Ports:
//   CP, CDN                     - clock (rising) / async active-low reset
//   req_valid/ready, req_arc_id - request handshake and arc id
//   req_edge                    - 1 = rising launch, 0 = falling launch
//   req_inv                     - 1 = inverting arc
//   launch                      - drive to the cell-under-test input pin
//   sense                       - cell-under-test output pin (asynchronous)
//   res_valid/ready             - result handshake
//   res_arc_id, res_delay       - echoed id, measured edge count
//   res_status                  - 00 ok, 01 timeout, 10 settle fail
module arc_delay_meter
    import arc_meter_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned ID_W       = 8,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned TIMEOUT    = 4095
) (
    input  logic            CP,
    input  logic            CDN,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [ID_W-1:0] req_arc_id,
    input  logic            req_edge,
    input  logic            req_inv,
    output logic            launch,
    input  logic            sense,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [ID_W-1:0] res_arc_id,
    output logic [CNT_W-1:0] res_delay,
    output logic [1:0]      res_status
);

    if (TIMEOUT >= (64'd1 << CNT_W)) begin : g_bad_timeout
        $error("TIMEOUT must be below 2**CNT_W");
    end
    if (SETTLE_CYC < 3) begin : g_bad_settle
        $error("SETTLE_CYC must be at least 3");
    end
    if (LOOPBACK_OFFSET != SYNC_STAGES + 1) begin : g_bad_offset
        $error("LOOPBACK_OFFSET inconsistent with SYNC_STAGES");
    end

    localparam logic [CNT_W-1:0] TimeoutC    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] SettleLastC = CNT_W'(SETTLE_CYC);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             edge_q, edge_d;
    logic             inv_q, inv_d;
    logic             launch_q, launch_d;
    logic             res_valid_q, res_valid_d;
    logic [ID_W-1:0]  res_arc_id_q, res_arc_id_d;
    logic [CNT_W-1:0] res_delay_q, res_delay_d;
    status_t          res_status_q, res_status_d;

    logic sense_s;
    logic init_exp;
    logic final_exp;

    sense_sync u_sense_sync (
        .CP  (CP),
        .CDN (CDN),
        .d   (sense),
        .q   (sense_s)
    );

    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign init_exp  = ~edge_q ^ inv_q;
    assign final_exp = edge_q ^ inv_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        edge_d       = edge_q;
        inv_d        = inv_q;
        launch_d     = launch_q;
        res_valid_d  = res_valid_q;
        res_arc_id_d = res_arc_id_q;
        res_delay_d  = res_delay_q;
        res_status_d = res_status_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    edge_d       = req_edge;
                    inv_d        = req_inv;
                    res_arc_id_d = req_arc_id;
                    launch_d     = ~req_edge;
                    cnt_d        = '0;
                    state_d      = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // Counter doubles as the settle timer; launch lands SETTLE_CYC+1
                // edges after acceptance.
                if (cnt_q == SettleLastC) begin
                    if (sense_s != init_exp) begin
                        res_delay_d  = '0;
                        res_status_d = ST_SETTLE_FAIL;
                        res_valid_d  = 1'b1;
                        state_d      = S_RESULT;
                    end else begin
                        launch_d = edge_q;
                        cnt_d    = '0;
                        state_d  = S_MEASURE;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_MEASURE: begin
                cnt_d = cnt_inc;
                // Detection is checked first so it wins over a same-cycle timeout.
                if (sense_s == final_exp) begin
                    res_delay_d  = cnt_inc;
                    res_status_d = ST_OK;
                    res_valid_d  = 1'b1;
                    state_d      = S_RESULT;
                end else if (cnt_inc == TimeoutC) begin
                    res_delay_d  = TimeoutC;
                    res_status_d = ST_TIMEOUT;
                    res_valid_d  = 1'b1;
                    state_d      = S_RESULT;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            edge_q       <= 1'b0;
            inv_q        <= 1'b0;
            launch_q     <= 1'b0;
            res_valid_q  <= 1'b0;
            res_arc_id_q <= '0;
            res_delay_q  <= '0;
            res_status_q <= ST_OK;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            edge_q       <= edge_d;
            inv_q        <= inv_d;
            launch_q     <= launch_d;
            res_valid_q  <= res_valid_d;
            res_arc_id_q <= res_arc_id_d;
            res_delay_q  <= res_delay_d;
            res_status_q <= res_status_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign launch     = launch_q;
    assign res_valid  = res_valid_q;
    assign res_arc_id = res_arc_id_q;
    assign res_delay  = res_delay_q;
    assign res_status = res_status_q;

endmodule

// File: tb/tb_arc_delay_meter.sv
module tb_arc_delay_meter;

    localparam int unsigned CNT_W      = 16;
    localparam int unsigned ID_W       = 8;
    localparam int unsigned SETTLE_CYC = 8;
    localparam int unsigned TIMEOUT    = 100;

    logic             CP = 1'b0;
    logic             CDN = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [ID_W-1:0]  req_arc_id = '0;
    logic             req_edge = 1'b0;
    logic             req_inv = 1'b0;
    logic             launch;
    logic             sense;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [ID_W-1:0]  res_arc_id;
    logic [CNT_W-1:0] res_delay;
    logic [1:0]       res_status;

    // Cell model: 0 = loopback, 1 = 10-cycle delay line, 2 = stuck level.
    int          mode = 0;
    logic        inv_m = 1'b0;
    logic        stuck = 1'b0;
    logic [15:0] hist = '0;

    int n_checks = 0;
    int n_fail = 0;
    int nl, nv;
    bit seen;

    arc_delay_meter #(
        .CNT_W      (CNT_W),
        .ID_W       (ID_W),
        .SETTLE_CYC (SETTLE_CYC),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .CP         (CP),
        .CDN        (CDN),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_arc_id (req_arc_id),
        .req_edge   (req_edge),
        .req_inv    (req_inv),
        .launch     (launch),
        .sense      (sense),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_arc_id (res_arc_id),
        .res_delay  (res_delay),
        .res_status (res_status)
    );

    always #5 CP = ~CP;

    always @(posedge CP) hist <= {hist[14:0], launch};

    assign sense = (mode == 0) ? (launch ^ inv_m) :
                   (mode == 1) ? (hist[9] ^ inv_m) : stuck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] id, input logic e, input logic inv);
        @(negedge CP);
        req_valid  = 1'b1;
        req_arc_id = id;
        req_edge   = e;
        req_inv    = inv;
        @(posedge CP);
        #1;
        req_valid = 1'b0;
    endtask

    // Counts edges after acceptance; records first launch change and res_valid.
    task automatic wait_res(input int budget, output int n_launch, output int n_valid);
        logic init;
        init     = launch;
        n_launch = -1;
        n_valid  = -1;
        for (int n = 1; n <= budget; n++) begin
            @(posedge CP);
            #1;
            if (n_launch < 0 && launch !== init) n_launch = n;
            if (res_valid === 1'b1) begin
                n_valid = n;
                break;
            end
        end
        if (n_valid < 0) chk("result_seen", {31'd0, res_valid}, 32'd1);
    endtask

    task automatic ack();
        @(negedge CP);
        res_ready = 1'b1;
        @(posedge CP);
        #1;
        res_ready = 1'b0;
    endtask

    initial begin
        // Reset values
        #1;
        chk("rst_launch", {31'd0, launch}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_res_delay", {16'd0, res_delay}, 32'd0);
        chk("rst_res_status", {30'd0, res_status}, 32'd0);
        chk("rst_res_arc_id", {24'd0, res_arc_id}, 32'd0);
        @(negedge CP);
        CDN = 1'b1;

        // T1: zero-delay loopback, rising, non-inverting
        mode = 0; inv_m = 1'b0;
        send(8'h12, 1'b1, 1'b0);
        chk("t1_init_level", {31'd0, launch}, 32'd0);
        wait_res(200, nl, nv);
        chk("t1_launch_at", nl, SETTLE_CYC + 1);
        chk("t1_delay", {16'd0, res_delay}, 32'd3);
        chk("t1_status", {30'd0, res_status}, 32'd0);
        chk("t1_id", {24'd0, res_arc_id}, 32'h12);
        chk("t1_latency", nv - nl, 32'd3);
        chk("t1_launch_end", {31'd0, launch}, 32'd1);
        chk("t1_req_ready", {31'd0, req_ready}, 32'd0);
        ack();
        chk("t1_valid_drop", {31'd0, res_valid}, 32'd0);
        chk("t1_idle_ready", {31'd0, req_ready}, 32'd1);

        // T2: 10-cycle inverting delay line, falling launch -> 13
        mode = 1; inv_m = 1'b1;
        send(8'h34, 1'b0, 1'b1);
        wait_res(200, nl, nv);
        chk("t2_launch_at", nl, SETTLE_CYC + 1);
        chk("t2_delay", {16'd0, res_delay}, 32'd13);
        chk("t2_status", {30'd0, res_status}, 32'd0);
        chk("t2_id", {24'd0, res_arc_id}, 32'h34);
        chk("t2_latency", nv - nl, 32'd13);
        chk("t2_launch_end", {31'd0, launch}, 32'd0);
        ack();

        // T3: output never switches -> timeout
        mode = 2; stuck = 1'b0;
        send(8'h56, 1'b1, 1'b0);
        wait_res(300, nl, nv);
        chk("t3_launch_at", nl, SETTLE_CYC + 1);
        chk("t3_delay", {16'd0, res_delay}, TIMEOUT);
        chk("t3_status", {30'd0, res_status}, 32'd1);
        chk("t3_latency", nv - nl, TIMEOUT);
        chk("t3_launch_end", {31'd0, launch}, 32'd1);
        ack();

        // T4: output stuck at the wrong initial level -> settle fail
        stuck = 1'b1;
        send(8'h78, 1'b1, 1'b0);
        chk("t4_init_level", {31'd0, launch}, 32'd0);
        wait_res(200, nl, nv);
        chk("t4_no_launch", nl, 32'hFFFF_FFFF);
        chk("t4_result_at", nv, SETTLE_CYC + 1);
        chk("t4_delay", {16'd0, res_delay}, 32'd0);
        chk("t4_status", {30'd0, res_status}, 32'd2);
        chk("t4_id", {24'd0, res_arc_id}, 32'h78);
        chk("t4_launch_end", {31'd0, launch}, 32'd0);
        ack();

        // T5: result stalled by res_ready low, new request waits for handshake
        mode = 0; inv_m = 1'b0;
        send(8'h9A, 1'b0, 1'b0);
        wait_res(200, nl, nv);
        chk("t5_delay", {16'd0, res_delay}, 32'd3);
        @(negedge CP);
        req_valid  = 1'b1;
        req_arc_id = 8'hBC;
        req_edge   = 1'b1;
        req_inv    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge CP);
            #1;
            chk("t5_stall_valid", {31'd0, res_valid}, 32'd1);
            chk("t5_stall_delay", {16'd0, res_delay}, 32'd3);
            chk("t5_stall_id", {24'd0, res_arc_id}, 32'h9A);
            chk("t5_stall_status", {30'd0, res_status}, 32'd0);
            chk("t5_stall_ready", {31'd0, req_ready}, 32'd0);
        end
        @(negedge CP);
        res_ready = 1'b1;
        @(posedge CP);
        #1;
        res_ready = 1'b0;
        chk("t5_hs_valid", {31'd0, res_valid}, 32'd0);
        chk("t5_hs_ready", {31'd0, req_ready}, 32'd1);
        @(posedge CP);
        #1;
        req_valid = 1'b0;
        chk("t5_accept_ready", {31'd0, req_ready}, 32'd0);
        chk("t5_accept_id", {24'd0, res_arc_id}, 32'hBC);
        wait_res(200, nl, nv);
        chk("t5b_launch_at", nl, SETTLE_CYC + 1);
        chk("t5b_delay", {16'd0, res_delay}, 32'd3);
        chk("t5b_status", {30'd0, res_status}, 32'd0);
        ack();

        // T6: reset mid-MEASURE aborts, next request measures normally
        send(8'hDE, 1'b1, 1'b0);
        repeat (SETTLE_CYC + 2) @(posedge CP);
        #1;
        chk("t6_launched", {31'd0, launch}, 32'd1);
        @(negedge CP);
        CDN = 1'b0;
        #1;
        chk("t6_rst_launch", {31'd0, launch}, 32'd0);
        chk("t6_rst_valid", {31'd0, res_valid}, 32'd0);
        chk("t6_rst_ready", {31'd0, req_ready}, 32'd1);
        @(negedge CP);
        CDN = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CP);
            #1;
            if (res_valid !== 1'b0) seen = 1'b1;
        end
        chk("t6_no_result", {31'd0, seen}, 32'd0);
        chk("t6_ready_after", {31'd0, req_ready}, 32'd1);
        send(8'hEF, 1'b1, 1'b0);
        wait_res(200, nl, nv);
        chk("t6b_launch_at", nl, SETTLE_CYC + 1);
        chk("t6b_delay", {16'd0, res_delay}, 32'd3);
        chk("t6b_status", {30'd0, res_status}, 32'd0);
        chk("t6b_id", {24'd0, res_arc_id}, 32'hEF);
        ack();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
